// File: rtl/truth_table_sequencer.sv
// Steps a combinational cut through every input vector, samples its output at the end of
// each hold window and compares the measured table with an expected one. Optional: FAIL_STOP_EN.
module truth_table_sequencer #(
  parameter int N_IN        = 3,
  parameter int HOLD_CYCLES = 10,
  parameter int CW          = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [2**N_IN-1:0]   exp_table_i,
  input  logic                 out_f_i,
  output logic [N_IN-1:0]      in_vec_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 fail_o,
  output logic [N_IN-1:0]      fail_idx_o,
  output logic [2**N_IN-1:0]   table_o
);

  localparam int TW = 2**N_IN;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(TW - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] in_vec_q, in_vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            fail_q, fail_d;
  logic [N_IN-1:0] fail_idx_q, fail_idx_d;
  logic [TW-1:0]   table_q, table_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic            mismatch;
  logic            stop;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      in_vec_q   <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      fail_idx_q <= '0;
      table_q    <= '0;
      exp_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_vec_q   <= in_vec_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      fail_idx_q <= fail_idx_d;
      table_q    <= table_d;
      exp_q      <= exp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_vec_d   = in_vec_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_d     = fail_q;
    fail_idx_d = fail_idx_q;
    table_d    = table_q;
    exp_d      = exp_q;
    mismatch   = 1'b0;
    stop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d    = SCAN;
          in_vec_d   = '0;
          cnt_d      = CNT_LOAD;
          busy_d     = 1'b1;
          table_d    = '0;
          fail_d     = 1'b0;
          fail_idx_d = '0;
          pass_d     = 1'b0;
          exp_d      = exp_table_i;
        end
      end

      SCAN: begin
        if (abort_i) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          in_vec_d = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          table_d[in_vec_q] = out_f_i;
          mismatch = (out_f_i != exp_q[in_vec_q]);
          if (mismatch && !fail_q) begin
            fail_d     = 1'b1;
            fail_idx_d = in_vec_q;
          end
          stop = (in_vec_q == LAST_VEC);
`ifdef FAIL_STOP_EN
          if (mismatch && !fail_q) stop = 1'b1;
`endif
          if (stop) begin
            // Pass must see the bit sampled on this same edge, hence table_d.
            state_d  = FINISH;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            in_vec_d = '0;
            pass_d   = (table_d == exp_q);
          end else begin
            in_vec_d = in_vec_q + N_IN'(1);
            cnt_d    = CNT_LOAD;
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        in_vec_d = '0;
      end
    endcase
  end

  assign in_vec_o   = in_vec_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign pass_o     = pass_q;
  assign fail_o     = fail_q;
  assign fail_idx_o = fail_idx_q;
  assign table_o    = table_q;

endmodule
